// File: rtl/output_router.sv
// Output router: latches the array's bottom-edge partial sums on the capture pulse
// and streams them to the output buffer at a persistent, wrapping write address.
//
// state | meaning
// IDLE  | waiting for capture and/or i_en with a valid buffer
// WRITE | streaming one buffered sum per cycle to the output buffer
// DONE  | context written, o_done held until i_en drops
module output_router #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_reg_clear,
  input  logic                       i_psum_out_en,
  input  logic [ROWS*DATA_WIDTH-1:0] i_psum,
  input  logic                       i_en,
  input  logic [ADDR_WIDTH-1:0]      i_route_size,
  output logic [DATA_WIDTH-1:0]      o_data_out,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_write_en,
  output logic                       o_done,
  output logic [ADDR_WIDTH-1:0]      o_total_writes
);

  localparam int IW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                     state;
  logic [ROWS*DATA_WIDTH-1:0] buf_q;
  logic                       buf_valid;
  logic [ADDR_WIDTH-1:0]      ptr;
  logic [IW-1:0]              idx;
  logic [IW-1:0]              n_lat;
  logic [IW-1:0]              n_req;

  always_comb begin
    n_req = IW'(ROWS);
    if (i_route_size < ADDR_WIDTH'(ROWS)) n_req = IW'(i_route_size);
  end

  assign o_total_writes = ptr;

  // idx holds the index of the next row to write; row 0 is issued on the IDLE exit edge
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      buf_q      <= '0;
      buf_valid  <= 1'b0;
      ptr        <= '0;
      idx        <= '0;
      n_lat      <= '0;
      o_data_out <= '0;
      o_addr     <= '0;
      o_write_en <= 1'b0;
      o_done     <= 1'b0;
    end else if (i_reg_clear) begin
      state      <= IDLE;
      buf_q      <= '0;
      buf_valid  <= 1'b0;
      ptr        <= '0;
      idx        <= '0;
      n_lat      <= '0;
      o_data_out <= '0;
      o_addr     <= '0;
      o_write_en <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_psum_out_en) begin
            buf_q     <= i_psum;
            buf_valid <= 1'b1;
          end else if (i_en && buf_valid) begin
            n_lat <= n_req;
            if (n_req != '0) begin
              state      <= WRITE;
              o_write_en <= 1'b1;
              o_data_out <= buf_q[DATA_WIDTH-1:0];
              o_addr     <= ptr;
              ptr        <= ptr + 1'b1;
              idx        <= IW'(1);
            end else begin
              state     <= DONE;
              o_done    <= 1'b1;
              buf_valid <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (idx == n_lat) begin
            state      <= DONE;
            o_write_en <= 1'b0;
            o_done     <= 1'b1;
            buf_valid  <= 1'b0;
          end else begin
            o_write_en <= 1'b1;
            o_data_out <= buf_q[idx*DATA_WIDTH +: DATA_WIDTH];
            o_addr     <= ptr;
            ptr        <= ptr + 1'b1;
            idx        <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!i_en) begin
            state  <= IDLE;
            o_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_router.sv
// Self-checking bench for output_router: random contexts checked against a
// write-list model built from the route size, captured rows and a wrapping pointer.
module tb_output_router;
  localparam int ROWS = 2;
  localparam int DW   = 16;
  localparam int AW   = 8;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               reg_clear = 1'b0;
  logic               pen = 1'b0;
  logic [ROWS*DW-1:0] psum = '0;
  logic               en = 1'b0;
  logic [AW-1:0]      rs = '0;
  logic [DW-1:0]      dout;
  logic [AW-1:0]      addr;
  logic               we;
  logic               done;
  logic [AW-1:0]      tot;

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;

  output_router #(.ROWS(ROWS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_psum_out_en(pen),
    .i_psum(psum), .i_en(en), .i_route_size(rs), .o_data_out(dout), .o_addr(addr),
    .o_write_en(we), .o_done(done), .o_total_writes(tot)
  );

  always #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk); reg_clear = 1'b1;
    @(negedge clk); reg_clear = 1'b0;
    ptr_m = 0;
  endtask

  // capture data, request route, then expect min(route,ROWS) writes in row order
  task automatic run_context(input logic [ROWS*DW-1:0] data, input int route,
                             input bit inject, input bit drop_en);
    logic [DW-1:0] rows [ROWS];
    int n;
    for (int r = 0; r < ROWS; r++) rows[r] = data[r*DW +: DW];
    n = (route < ROWS) ? route : ROWS;
    @(negedge clk); psum = data; pen = 1'b1;
    @(negedge clk); pen = 1'b0; rs = AW'(route); en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (we !== 1'b1 || addr !== AW'(ptr_m) || dout !== rows[k]) begin
        failures++;
        $display("FAIL write[%0d]: got we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                 k, we, addr, dout, ptr_m, rows[k]);
      end
      ptr_m = (ptr_m + 1) % 256;
      if (inject && k == 0) begin psum = ~data; pen = 1'b1; end
      @(negedge clk); pen = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || we !== 1'b0) begin
      failures++;
      $display("FAIL done_rise: got done=%b we=%b, required done=1 we=0", done, we);
    end
    checks++;
    if (tot !== AW'(ptr_m)) begin
      failures++;
      $display("FAIL total_writes: got %0d, required %0d", tot, ptr_m);
    end
    if (drop_en) begin
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_fall: got done=%b, required 0", done);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dout, addr, we, done, tot} !== '0) begin
      failures++;
      $display("FAIL reset_state: got data=%h addr=%0d we=%b done=%b tot=%0d, required all 0",
               dout, addr, we, done, tot);
    end
    @(negedge clk); nrst = 1'b1;
    @(negedge clk); psum = {16'h00BB, 16'h00AA}; pen = 1'b1;
    @(negedge clk); pen = 1'b0; rs = 8'd2; en = 1'b1;
    @(negedge clk);
    checks++;
    if (we !== 1'b1) begin
      failures++;
      $display("FAIL reset_prewrite: got we=%b, required 1", we);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({dout, addr, we, done, tot} !== '0) begin
      failures++;
      $display("FAIL reset_midwrite: got data=%h addr=%0d we=%b done=%b tot=%0d, required all 0",
               dout, addr, we, done, tot);
    end
    @(negedge clk); nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || done !== 1'b0 || addr !== '0 || tot !== '0) begin
        failures++;
        $display("FAIL reset_idle: got we=%b done=%b addr=%0d tot=%0d, required 0 0 0 0",
                 we, done, addr, tot);
      end
    end
    en = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_basic();
    run_context({16'h0022, 16'h0011}, 2, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_clear();
    run_context({DW'($urandom), DW'($urandom)}, 2, 1'b0, 1'b1);
    run_context({DW'($urandom), DW'($urandom)}, 2, 1'b1, 1'b1);
    checks++;
    if (tot !== 8'd4) begin
      failures++;
      $display("FAIL b2b_total: got %0d, required 4", tot);
    end
  endtask

  task automatic test_short_routes();
    run_context({DW'($urandom), DW'($urandom)}, 1, 1'b0, 1'b1);
    run_context({DW'($urandom), DW'($urandom)}, 0, 1'b0, 1'b1);
    run_context({DW'($urandom), DW'($urandom)}, 200, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    do_clear();
    for (int i = 0; i < 127; i++) run_context({DW'($urandom), DW'($urandom)}, 2, 1'b0, 1'b1);
    run_context({DW'($urandom), DW'($urandom)}, 2, 1'b0, 1'b1);
    checks++;
    if (tot !== 8'd0) begin
      failures++;
      $display("FAIL wrap_total: got %0d, required 0", tot);
    end
  endtask

  task automatic test_reg_clear();
    run_context({DW'($urandom), DW'($urandom)}, 2, 1'b0, 1'b0);
    reg_clear = 1'b1;
    @(negedge clk); reg_clear = 1'b0;
    ptr_m = 0;
    checks++;
    if (done !== 1'b0 || tot !== '0) begin
      failures++;
      $display("FAIL clear_done: got done=%b tot=%0d, required done=0 tot=0", done, tot);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL clear_nowrite: got we=%b done=%b, required 0 0", we, done);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_context({DW'($urandom), DW'($urandom)}, $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_routes();
    test_wrap();
    test_reg_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_router.md
Name: output_router

Overview:
- Downstream consumer of the top controller's output-router handshake.
- On the psum-capture pulse it latches the ROWS partial sums from the systolic array's bottom edge.
- When enabled, it writes those sums one per cycle to the output buffer at an auto-incrementing address, then signals completion back to the controller.
- Its completion output feeds the controller's output-router-done input; the controller's output-router enable and psum-out enable drive it.

Parameters:
ROWS, 2, number of array rows, i.e. partial sums captured per context
DATA_WIDTH, 16, width of one partial sum
ADDR_WIDTH, 8, output buffer address width; also the width of route size

Ports:
i_clk  in  1  clock, rising edge
i_nrst  in  1  asynchronous active-low reset
i_reg_clear  in  1  synchronous clear, same effect as reset
i_psum_out_en  in  1  single-cycle capture pulse from controller
i_psum  in  ROWS*DATA_WIDTH  partial sums; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
i_en  in  1  write enable from controller; level, held until o_done seen
i_route_size  in  ADDR_WIDTH  number of sums to write this context; sampled at IDLE->WRITE
o_data_out  out  DATA_WIDTH  write data to output buffer
o_addr  out  ADDR_WIDTH  write address
o_write_en  out  1  write strobe, one word per high cycle
o_done  out  1  context written; level, held until i_en drops
o_total_writes  out  ADDR_WIDTH  writes since reset/clear; equals next write address

Behaviour:
- Reset (i_nrst low, async) and i_reg_clear (sync, highest priority) set the following to 0: state=IDLE, all outputs, capture buffer, buf_valid, write pointer, index.
- Capture:
  - In IDLE, an i_psum_out_en high at a clock edge copies all ROWS sums into the buffer and sets buf_valid.
  - A pulse in WRITE or DONE is ignored, with no buffer change.
  - A capture pulse in IDLE together with i_en: capture takes effect and the transition to WRITE waits for the next edge.
- Write count: N = min(i_route_size, ROWS), latched on entry to WRITE.
- State machine, with all outputs registered:
  - IDLE: if i_en & buf_valid & N>0, go to WRITE and index=0. If i_en & buf_valid & N==0, go directly to DONE with no writes. Otherwise stay in IDLE. i_en without buf_valid waits indefinitely.
  - WRITE: each cycle drive o_write_en=1, o_data_out=buffer[index], o_addr=pointer; then index+1 and pointer+1.
    - After the write at index N-1, go to DONE and clear buf_valid.
    - Rows are written in order from row 0 to row N-1.
    - If i_en drops mid-WRITE, the writes still complete; the controller does not do this in normal operation.
  - DONE: o_done=1 and o_write_en=0. When i_en is sampled low, go to IDLE with o_done=0.
- Latency:
  - First o_write_en is high in the cycle after the edge that samples i_en=1 in IDLE.
  - The N writes occupy N consecutive cycles.
  - o_done rises in the cycle immediately after the last write.
- Handshake with controller:
  - The controller drops i_en one edge after seeing o_done.
  - o_done falls one edge after that.
  - o_done is therefore low before the controller returns to IDLE and re-evaluates its start condition, so there is no double start.
- Pointer:
  - The pointer persists across contexts, so consecutive contexts pack contiguously.
  - It wraps modulo 2^ADDR_WIDTH silently (0xFF+1=0x00 at 8 bits).
  - It is cleared only by reset or i_reg_clear.
  - o_total_writes mirrors the pointer.
- Data is passed unmodified, with no sign change or saturation.

Test Plan:
- Reset values: assert i_nrst=0 mid-WRITE -> all outputs 0 immediately; after release, state is IDLE and o_addr=0.
- Basic context:
  - Stimulus: ROWS=2, capture i_psum={row1=0x0022,row0=0x0011}, i_route_size=2, i_en=1.
  - Required: writes (addr0,0x0011) then (addr1,0x0022) on consecutive cycles; o_done high the next cycle.
  - Required: o_done low one cycle after i_en drops.
- Two back-to-back contexts of 2 each -> addresses 0,1,2,3; o_total_writes=4; a capture pulse injected during WRITE does not alter the second context's data.
- i_route_size=1 -> a single write of row 0; i_route_size=0 -> no o_write_en, o_done asserts the cycle after i_en is sampled.
- Wrap: preload 127 contexts of 2 (pointer=254), then one more -> addresses 254,255, and the pointer becomes 0.
- i_reg_clear pulse in DONE -> next cycle o_done=0, pointer=0, buf_valid=0; a following i_en without capture produces no writes.
